shift_rotate_sequencer: RTL and testbench

SHIFT_ROTATE_SEQUENCER -- requirements
Module: shift_rotate_sequencer

---
 rtl/alu_shift_pkg.sv | 26 ++
 rtl/shift_rotate_step.sv | 30 +++
 rtl/shift_rotate_sequencer.sv | 113 +++++++++++
 tb/tb_shift_rotate_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared encodings for the shift/rotate sequencer: op codes, FSM states and
// the fast-mode step size.
package alu_shift_pkg;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Largest number of positions moved in one RUN cycle in fast mode.
   localparam int FAST_STEP = 4;

   function automatic logic is_legal_op(input logic [2:0] op);
      return op <= 3'(OP_ROR);
   endfunction

endpackage

// File: rtl/shift_rotate_step.sv
// Combinational single step: moves a value by 0..4 positions for one op.
module shift_rotate_step
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 128
) (
   input  logic [WIDTH-1:0] value,
   input  logic [2:0]       op,
   input  logic [2:0]       step,
   input  logic             fill,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] fill_mask;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      result    = value;
      fill_mask = ~({WIDTH{1'b1}} >> step);
      case (op)
         OP_SLL:  result = value << step;
         OP_SRL:  result = value >> step;
         OP_SRA:  result = (value >> step) | (fill ? fill_mask : '0);
         OP_ROL:  result = (value << step) | (value >> (WIDTH - int'(step)));
         OP_ROR:  result = (value >> step) | (value << (WIDTH - int'(step)));
         default: result = value;
      endcase
   end

endmodule

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle shift/rotate sequencer: IDLE/RUN/DONE FSM stepping a working register.
// Define SHIFT_SEQ_FAST_STEP_EN to move up to 4 positions per cycle instead of 1.
module shift_rotate_sequencer
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             done,
   output logic             busy,
   output logic             err
);

   state_e           state, state_next;
   logic [WIDTH-1:0] work, stepped;
   logic [CNT_W-1:0] remaining;
   logic [2:0]       op_q;
   logic             fill_q;
   logic             err_q;
   logic [2:0]       step;
   logic             legal, last_step;

`ifdef SHIFT_SEQ_FAST_STEP_EN
   assign step = (remaining >= CNT_W'(FAST_STEP)) ? 3'(FAST_STEP) : 3'(remaining);
`else
   assign step = 3'd1;
`endif

   assign legal     = is_legal_op(op);
   assign last_step = (remaining == CNT_W'(step));
   assign err       = err_q;

   shift_rotate_step #(.WIDTH(WIDTH)) u_step (
      .value  (work),
      .op     (op_q),
      .step   (step),
      .fill   (fill_q),
      .result (stepped)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_next = (legal && amount != '0) ? RUN : DONE;
         end
         RUN: begin
            busy = 1'b1;
            if (last_step) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: registers are written with <= only, so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         work      <= '0;
         remaining <= '0;
         op_q      <= 3'(OP_SLL);
         fill_q    <= 1'b0;
         dout      <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  if (legal && amount != '0) begin
                     work      <= din;
                     remaining <= amount;
                     op_q      <= op;
                     fill_q    <= din[WIDTH-1];
                  end else begin
                     // Zero distance or illegal op: pass the operand straight through.
                     dout  <= din;
                     err_q <= ~legal;
                  end
               end
            end
            RUN: begin
               work      <= stepped;
               remaining <= remaining - CNT_W'(step);
               if (last_step) dout <= stepped;
            end
            DONE: err_q <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Scoreboard bench for shift_rotate_sequencer: directed vectors plus a reference-model batch.
module tb_shift_rotate_sequencer;

   localparam int WIDTH = 128;
   localparam int CNT_W = 7;
   localparam logic [WIDTH-1:0] MSB = {1'b1, 127'b0};

   typedef struct {
      logic [WIDTH-1:0] dout;
      logic             err;
      int               acc;
      int               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [2:0]       op = 3'd0;
   logic [CNT_W-1:0] amount = '0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             done, busy, err;

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   exp_t             sbq[$];
   logic [WIDTH-1:0] last_dout = '0;

   shift_rotate_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .amount      (amount),
      .din         (din),
      .dout        (dout),
      .done        (done),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] o, input int a);
      if (a == 0 || o > 3'd4) return 1;
`ifdef SHIFT_SEQ_FAST_STEP_EN
      return (a + 3) / 4 + 1;
`else
      return a + 1;
`endif
   endfunction

   // Whole-distance reference, independent of the stepping datapath.
   function automatic logic [WIDTH-1:0] model(input logic [2:0] o, input int a, input logic [WIDTH-1:0] d);
      if (a == 0) return d;
      case (o)
         3'd0:    return d << a;
         3'd1:    return d >> a;
         3'd2:    return WIDTH'($signed(d) >>> a);
         3'd3:    return (d << a) | (d >> (WIDTH - a));
         3'd4:    return (d >> a) | (d << (WIDTH - a));
         default: return d;
      endcase
   endfunction

   task automatic send(input logic [2:0] o, input int a, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] ed, input bit keep);
      int waited = 0;
      @(negedge clk);
      op = o;
      amount = CNT_W'(a);
      din = d;
      start_valid = 1'b1;
      while (!start_ready) begin
         check("busy_while_not_ready", WIDTH'(busy), WIDTH'(1));
         waited++;
         if (waited > 2000) begin
            check("accept_timeout", WIDTH'(0), WIDTH'(1));
            start_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      sbq.push_back('{dout: ed, err: (o > 3'd4), acc: cyc, lat: exp_lat(o, a)});
      if (!keep) begin
         @(negedge clk);
         start_valid = 1'b0;
      end
   endtask

   // Monitor: compares every done pulse against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            if (done) begin
               if (sbq.size() == 0) begin
                  check("spurious_done", WIDTH'(done), WIDTH'(0));
               end else begin
                  e = sbq.pop_front();
                  check("dout", dout, e.dout);
                  check("err", WIDTH'(err), WIDTH'(e.err));
                  check("latency", WIDTH'(cyc - e.acc), WIDTH'(e.lat));
                  last_dout = e.dout;
               end
            end else begin
               check("err_outside_done", WIDTH'(err), WIDTH'(0));
               check("dout_hold", dout, last_dout);
            end
         end
      end
   end

   initial begin
      logic [2:0]       ro;
      int               ra;
      logic [WIDTH-1:0] rd;
      int               w;

      repeat (2) @(negedge clk);
      check("rst_dout", dout, '0);
      check("rst_done", WIDTH'(done), WIDTH'(0));
      check("rst_err", WIDTH'(err), WIDTH'(0));
      check("rst_busy", WIDTH'(busy), WIDTH'(0));
      check("rst_ready", WIDTH'(start_ready), WIDTH'(1));
      rst = 1'b0;

      // Directed vectors with hand-computed results.
      send(3'd0, 5,   WIDTH'(1), WIDTH'(128'h20), 1'b0);
      send(3'd2, 4,   MSB, {5'b11111, 123'b0}, 1'b0);
      send(3'd4, 127, WIDTH'(1), WIDTH'(2), 1'b0);
      send(3'd3, 1,   MSB, WIDTH'(1), 1'b0);
      send(3'd3, 127, WIDTH'(1), MSB, 1'b0);
      send(3'd1, 0,   WIDTH'(128'hDEADBEEF), WIDTH'(128'hDEADBEEF), 1'b0);
      send(3'd5, 9,   WIDTH'(128'h1234), WIDTH'(128'h1234), 1'b0);
      send(3'd7, 0,   WIDTH'(128'h55), WIDTH'(128'h55), 1'b0);
      send(3'd1, 127, '1, WIDTH'(1), 1'b0);
      send(3'd0, 127, '1, MSB, 1'b0);
      send(3'd2, 2,   {2'b01, 126'b0}, {4'b0001, 124'b0}, 1'b0);
      send(3'd4, 1,   WIDTH'(3), MSB | WIDTH'(1), 1'b0);
      send(3'd0, 4,   WIDTH'(128'hF), WIDTH'(128'hF0), 1'b0);
      send(3'd1, 3,   WIDTH'(128'h80), WIDTH'(128'h10), 1'b0);
      send(3'd3, 8,   {8'hA5, 120'b0}, WIDTH'(128'hA5), 1'b0);

      // Valid held through RUN: the second command waits for IDLE.
      send(3'd3, 6, WIDTH'(128'h5), WIDTH'(128'h140), 1'b1);
      send(3'd1, 8, WIDTH'(128'hFF00), WIDTH'(128'hFF), 1'b0);

      // Reset mid-RUN with a competing start_valid: no done, back to IDLE.
      send(3'd0, 50, WIDTH'(1), WIDTH'(1) << 50, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      start_valid = 1'b1;
      op = 3'd0;
      amount = CNT_W'(3);
      din = WIDTH'(128'h77);
      void'(sbq.pop_back());
      last_dout = '0;
      @(negedge clk);
      check("abort_dout", dout, '0);
      check("abort_done", WIDTH'(done), WIDTH'(0));
      check("abort_busy", WIDTH'(busy), WIDTH'(0));
      rst = 1'b0;
      start_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", WIDTH'(start_ready), WIDTH'(1));
      check("post_rst_busy", WIDTH'(busy), WIDTH'(0));

      // Reference-model batch.
      for (int i = 0; i < 1000; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = int'($urandom_range(0, 127));
         rd = {$urandom, $urandom, $urandom, $urandom};
         send(ro, ra, rd, model(ro, ra, rd), 1'b0);
      end

      w = 0;
      while (sbq.size() != 0 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("scoreboard_drained", WIDTH'(sbq.size()), WIDTH'(0));
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
